ps2_key_encoder: RTL and testbench



---
 rtl/ps2_key_encoder.sv | 136 +++++++++++++
 tb/tb_ps2_key_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver. It turns the raw clock/data pins into the toggle-strobed 11-bit ps2_key word.
// Bytes carry the E0/F0 prefixes and the E1 pause sequence. Errors in a frame are flagged on frame_err.
module ps2_key_encoder #(
    parameter int CLK_HZ     = 48000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILT       = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam int FW       = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] to_cnt;
    logic [2:0]    skip;
    state_t        state;

    logic       fall;
    logic [7:0] rx_byte;
    logic       frame_ok;

    assign fall     = filt_prev & ~filt_clk;
    assign rx_byte  = shift[8:1];
    // shift[0] is the start bit and shift[9] is parity. The stop bit is still on the data line.
    assign frame_ok = ~shift[0] & (^shift[9:1]) & data_s2;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // The filtered level flips only after FILT consecutive disagreeing samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            to_cnt    <= '0;
            skip      <= '0;
            state     <= ST_IDLE;
            ps2_key   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                        skip      <= '0;
                    end else if (state == ST_PAUSE) begin
                        skip <= skip - 1'b1;
                        if (skip == 3'd1) state <= ST_IDLE;
                    end else if (rx_byte == 8'hE1) begin
                        state <= ST_PAUSE;
                        skip  <= 3'd7;
                    end else if (rx_byte == 8'hE0) begin
                        if (state == ST_IDLE)     state <= ST_EXT;
                        else if (state == ST_BRK) state <= ST_EXT_BRK;
                    end else if (rx_byte == 8'hF0) begin
                        if (state == ST_IDLE)     state <= ST_BRK;
                        else if (state == ST_EXT) state <= ST_EXT_BRK;
                    end else begin
                        ps2_key <= {~ps2_key[10],
                                    ~(state == ST_BRK || state == ST_EXT_BRK),
                                    (state == ST_EXT || state == ST_EXT_BRK),
                                    rx_byte};
                        state   <= ST_IDLE;
                    end
                end else begin
                    shift   <= {data_s2, shift[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                // Only a partly received frame can time out. The edge branch above takes priority.
                if (to_cnt == TW'(TO_LIMIT)) begin
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                    state     <= ST_IDLE;
                    skip      <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder. It drives directed keyboard frames and checks every output event against a byte-level model.
module tb_ps2_key_encoder;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [10:0] exp_q[$];
    logic [10:0] m_key = '0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    int          m_pause = 0;

    ps2_key_encoder dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #10 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Byte-level model. It tracks pending prefixes as flags and counts the pause bytes still to swallow.
    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
        end else if (b == 8'hE1) begin
            m_pause = 7;
            m_ext   = 1'b0;
            m_brk   = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            exp_q.push_back(m_key);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (half) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (30) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_parity, input int half);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        if (bad_parity) model_err();
        else model_byte(b);
        send_bits(fr, 11, half);
    endtask

    // Compare process. Each change of ps2_key must match the next predicted event. frame_err pulses are one cycle wide.
    logic [10:0] last_key = '0;
    logic        err_prev = 1'b0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            last_key = '0;
            err_prev = 1'b0;
        end else begin
            if (ps2_key !== last_key) begin
                if (exp_q.size() == 0) check("unexpected_event", 32'(ps2_key), 32'(last_key));
                else check("event_key", 32'(ps2_key), 32'(exp_q.pop_front()));
                last_key = ps2_key;
            end
            if (frame_err === 1'b1) begin
                err_seen++;
                if (err_prev) check("err_width", 32'd2, 32'd1);
            end
            err_prev = frame_err;
        end
    end

    initial begin
        int waited;
        repeat (5) @(negedge clk_sys);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);

        // Single make code at 12.5 kHz: 48 MHz / 12.5 kHz / 2 = 1920 cycles per half bit.
        send_byte(8'h29, 1'b0, 1920);
        check("make_key", 32'(ps2_key), 32'h629);
        check("make_err", 32'(err_seen), 32'd0);

        send_byte(8'hE0, 1'b0, 20);
        check("e0_no_event", 32'(ps2_key), 32'h629);
        send_byte(8'hF0, 1'b0, 20);
        check("f0_no_event", 32'(ps2_key), 32'h629);
        send_byte(8'h75, 1'b0, 20);
        check("ext_brk_key", 32'(ps2_key), 32'h175);

        send_byte(8'hE0, 1'b0, 20);
        send_byte(8'h1C, 1'b1, 20);
        check("parity_err", 32'(err_seen), 32'd1);
        check("parity_key_held", 32'(ps2_key), 32'h175);
        send_byte(8'h75, 1'b0, 20);
        check("after_parity_key", 32'(ps2_key), 32'h675);

        // Timeout: five bits of a frame, then idle. The error must come about 9600 cycles after the last filtered edge.
        model_err();
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 20);
        waited = 30;
        while (frame_err !== 1'b1 && waited < 12000) begin
            @(negedge clk_sys);
            waited++;
        end
        check("timeout_seen", 32'(frame_err === 1'b1), 32'd1);
        check("timeout_early", 32'(waited >= 9570), 32'd1);
        check("timeout_late", 32'(waited <= 9620), 32'd1);
        repeat (10) @(negedge clk_sys);
        check("timeout_err_cnt", 32'(err_seen), 32'd2);
        send_byte(8'h1C, 1'b0, 20);
        check("after_timeout_key", 32'(ps2_key), 32'h21C);

        send_byte(8'hE1, 1'b0, 20);
        send_byte(8'h14, 1'b0, 20);
        send_byte(8'h77, 1'b0, 20);
        send_byte(8'hE1, 1'b0, 20);
        send_byte(8'hF0, 1'b0, 20);
        send_byte(8'h14, 1'b0, 20);
        send_byte(8'hF0, 1'b0, 20);
        send_byte(8'h77, 1'b0, 20);
        check("pause_no_event", 32'(ps2_key), 32'h21C);
        send_byte(8'h16, 1'b0, 20);
        check("after_pause_key", 32'(ps2_key), 32'h616);

        // A 3-cycle glitch is shorter than the filter, so the next frame must still line up.
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
        send_byte(8'h5A, 1'b0, 20);
        check("glitch_key", 32'(ps2_key), 32'h25A);
        check("glitch_err_cnt", 32'(err_seen), 32'd2);

        // Pulse reset after part of a frame. State is cleared and the next full frame decodes from scratch.
        send_bits({1'b1, 1'b0, 8'h44, 1'b0}, 4, 20);
        reset_n = 1'b0;
        exp_q.delete();
        m_key   = '0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
        repeat (3) @(negedge clk_sys);
        check("midreset_key", 32'(ps2_key), 32'h000);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        send_byte(8'h33, 1'b0, 20);
        check("after_reset_key", 32'(ps2_key), 32'h633);

        repeat (50) @(negedge clk_sys);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("err_total", 32'(err_seen), 32'(exp_err));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
